instr_decode_stage: RTL
=======================

Name: instr_decode_stage

Overview:
- Registered decode stage between instruction fetch and the single-cycle control path.
- Accepts a 32-bit MIPS instruction word and its PC over a valid/ready handshake.
- Produces the 32-bit one-hot instruction vector that the controller consumes, together with a passthrough copy of the word and PC.
- Has a 2-entry skid buffer, a flush input for redirects, and a saturating count of illegal encodings.

Parameters:
- CNT_W, 8, width of the illegal-instruction counter.
- PC_W, 32, width of the PC field carried with each instruction.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- flush  input  1  discard all buffered and incoming instructions this cycle.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept; equals NOT skid_valid.
- in_instr  input  32  raw instruction word.
- in_pc  input  PC_W  PC of in_instr.
- out_valid  output  1  decoded entry present.
- out_ready  input  1  downstream accepts the decoded entry.
- out_onehot  output  32  one-hot instruction vector; all-zero if illegal.
- out_instr  output  32  registered instruction word, for field extraction downstream.
- out_pc  output  PC_W  registered PC.
- out_illegal  output  1  entry held no legal encoding.
- illegal_cnt  output  CNT_W  count of accepted illegal entries; saturates.

Behaviour:
- One-hot bit map:
  - 0..9: add, addu, sub, subu, and, or, xor, nor, slt, sltu (op 0; funct 20,21,22,23,24,25,26,27,2A,2B hex).
  - 10..16: sll, srl, sra, sllv, srlv, srav, jr (op 0; funct 00,02,03,04,06,07,08).
  - 17..21: addi, addiu, andi, ori, xori (op 08,09,0C,0D,0E).
  - 22..25: lw, sw, beq, bne (op 23,2B,04,05).
  - 26..28: slti, sltiu, lui (op 0A,0B,0F).
  - 29..30: j, jal (op 02,03).
  - Bit 31 is always 0.
- Decoding matches op and funct only; other fields are ignored. 0x00000000 decodes as sll (bit 10).
- Any other op/funct combination gives out_onehot = 0 and out_illegal = 1. The entry still flows downstream.
- Storage is an output register plus one skid register.
  - Accept = in_valid AND in_ready. Decoding happens on the input side, before the register.
  - Latency is 1 cycle: an entry accepted at edge N is on the outputs after edge N.
- Output register load rules:
  - Loads when empty, or when out_ready = 1 in the same cycle.
  - When occupied and out_ready = 0, an accepted entry goes to the skid register.
  - When the output drains and skid_valid = 1, the skid entry moves to the output. A simultaneous accept is impossible because in_ready = 0.
- Ordering is strictly FIFO. No entry is dropped or duplicated without a flush.
- Full condition: skid_valid = 1, so in_ready = 0. in_ready returns to 1 the cycle after the skid entry moves forward.
- Flush:
  - Both entries are invalidated at the edge.
  - An input accepted in the flush cycle is discarded and is not counted.
  - Flush overrides out_ready.
  - The cycle after a flush: out_valid = 0, in_ready = 1.
- illegal_cnt increments by 1 on each non-flushed accept of an illegal entry. It holds at 2^CNT_W-1. It is cleared only by reset.
- Reset values:
  - out_valid = 0, skid_valid = 0, in_ready = 1.
  - out_onehot = 0, out_instr = 0, out_pc = 0, out_illegal = 0, illegal_cnt = 0.
  - A reset asserted mid-stream clears everything immediately.
- Output data registers hold their value while out_valid = 0.

Decomposition:
- Shared header mips_defines.vh holds:
  - opcode and funct constants;
  - one-hot bit index constants (IDX_ADD=0 … IDX_JAL=30).
- The controller uses the same index constants.
- Sub-module instr_onehot_dec: purely combinational instr[31:0] -> {onehot[31:0], illegal}. It is instantiated once, on the input side.

Test Plan:
- 0x00221820 (add), then 0x8C220004 (lw), then 0x0C000010 (jal), with out_ready = 1.
  - out_onehot must be 0x00000001, 0x00400000, 0x40000000 on consecutive cycles, each one cycle after its accept.
  - out_pc must match the input PC.
- 0xFC000000 (op 3F), then 0x00000001 (op 0, funct 01).
  - out_onehot = 0 and out_illegal = 1 for both.
  - illegal_cnt = 2.
- 0x00000000 -> out_onehot = 0x00000400, out_illegal = 0.
- Backpressure: hold out_ready = 0 and offer 3 instructions.
  - Exactly 2 are accepted; in_ready = 0 after the second.
  - Raise out_ready: outputs appear in order, in_ready = 1 one cycle after the skid drains, and the third is then accepted.
- With 2 entries buffered, assert flush together with in_valid = 1 carrying an illegal word.
  - Next cycle: out_valid = 0, in_ready = 1, illegal_cnt unchanged.
- With CNT_W = 2, send 5 illegal words -> illegal_cnt = 3.
  - Assert rst_n low mid-stream: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/instr_decode_stage_pkg.sv
// Shared MIPS encoding constants and one-hot bit indices for the decode stage
// and the controller that consumes its one-hot vector.
package instr_decode_stage_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // One-hot bit positions; bit 31 is never set
  localparam int IDX_ADD   = 0;
  localparam int IDX_ADDU  = 1;
  localparam int IDX_SUB   = 2;
  localparam int IDX_SUBU  = 3;
  localparam int IDX_AND   = 4;
  localparam int IDX_OR    = 5;
  localparam int IDX_XOR   = 6;
  localparam int IDX_NOR   = 7;
  localparam int IDX_SLT   = 8;
  localparam int IDX_SLTU  = 9;
  localparam int IDX_SLL   = 10;
  localparam int IDX_SRL   = 11;
  localparam int IDX_SRA   = 12;
  localparam int IDX_SLLV  = 13;
  localparam int IDX_SRLV  = 14;
  localparam int IDX_SRAV  = 15;
  localparam int IDX_JR    = 16;
  localparam int IDX_ADDI  = 17;
  localparam int IDX_ADDIU = 18;
  localparam int IDX_ANDI  = 19;
  localparam int IDX_ORI   = 20;
  localparam int IDX_XORI  = 21;
  localparam int IDX_LW    = 22;
  localparam int IDX_SW    = 23;
  localparam int IDX_BEQ   = 24;
  localparam int IDX_BNE   = 25;
  localparam int IDX_SLTI  = 26;
  localparam int IDX_SLTIU = 27;
  localparam int IDX_LUI   = 28;
  localparam int IDX_J     = 29;
  localparam int IDX_JAL   = 30;

  function automatic logic [31:0] onehot_bit(input int idx);
    logic [31:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/instr_decode_stage_onehot_dec.sv
// Combinational MIPS decoder: op/funct -> one-hot instruction vector plus
// an illegal flag when nothing matches. Other instruction fields are ignored.
module instr_onehot_dec
  import instr_decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] onehot,
  output logic        illegal
);

  logic [5:0] op;
  logic [5:0] funct;

  assign op    = instr[31:26];
  assign funct = instr[5:0];

  always_comb begin
    onehot = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  onehot = onehot_bit(IDX_ADD);
          FN_ADDU: onehot = onehot_bit(IDX_ADDU);
          FN_SUB:  onehot = onehot_bit(IDX_SUB);
          FN_SUBU: onehot = onehot_bit(IDX_SUBU);
          FN_AND:  onehot = onehot_bit(IDX_AND);
          FN_OR:   onehot = onehot_bit(IDX_OR);
          FN_XOR:  onehot = onehot_bit(IDX_XOR);
          FN_NOR:  onehot = onehot_bit(IDX_NOR);
          FN_SLT:  onehot = onehot_bit(IDX_SLT);
          FN_SLTU: onehot = onehot_bit(IDX_SLTU);
          FN_SLL:  onehot = onehot_bit(IDX_SLL);
          FN_SRL:  onehot = onehot_bit(IDX_SRL);
          FN_SRA:  onehot = onehot_bit(IDX_SRA);
          FN_SLLV: onehot = onehot_bit(IDX_SLLV);
          FN_SRLV: onehot = onehot_bit(IDX_SRLV);
          FN_SRAV: onehot = onehot_bit(IDX_SRAV);
          FN_JR:   onehot = onehot_bit(IDX_JR);
          default: onehot = '0;
        endcase
      end
      OP_ADDI:  onehot = onehot_bit(IDX_ADDI);
      OP_ADDIU: onehot = onehot_bit(IDX_ADDIU);
      OP_ANDI:  onehot = onehot_bit(IDX_ANDI);
      OP_ORI:   onehot = onehot_bit(IDX_ORI);
      OP_XORI:  onehot = onehot_bit(IDX_XORI);
      OP_LW:    onehot = onehot_bit(IDX_LW);
      OP_SW:    onehot = onehot_bit(IDX_SW);
      OP_BEQ:   onehot = onehot_bit(IDX_BEQ);
      OP_BNE:   onehot = onehot_bit(IDX_BNE);
      OP_SLTI:  onehot = onehot_bit(IDX_SLTI);
      OP_SLTIU: onehot = onehot_bit(IDX_SLTIU);
      OP_LUI:   onehot = onehot_bit(IDX_LUI);
      OP_J:     onehot = onehot_bit(IDX_J);
      OP_JAL:   onehot = onehot_bit(IDX_JAL);
      default:  onehot = '0;
    endcase
  end

  assign illegal = (onehot == '0);

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: decode on the input side, then an output register
// backed by a single skid register so fetch sees a registered in_ready.
module instr_decode_stage
  import instr_decode_stage_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_onehot,
  output logic [31:0]      out_instr,
  output logic [PC_W-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its data stay stable until that transfer, and ready
  // never depends combinationally on valid of the same interface.

  logic [31:0]     dec_onehot;
  logic            dec_illegal;

  logic            skid_valid;
  logic [31:0]     skid_onehot;
  logic [31:0]     skid_instr;
  logic [PC_W-1:0] skid_pc;
  logic            skid_illegal;

  logic            accept;
  logic            out_free;

  instr_onehot_dec u_dec (
    .instr   (in_instr),
    .onehot  (dec_onehot),
    .illegal (dec_illegal)
  );

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign out_free = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_onehot   <= '0;
      out_instr    <= '0;
      out_pc       <= '0;
      out_illegal  <= 1'b0;
      skid_valid   <= 1'b0;
      skid_onehot  <= '0;
      skid_instr   <= '0;
      skid_pc      <= '0;
      skid_illegal <= 1'b0;
    end else if (flush) begin
      // Data registers keep their contents; only the valid bits drop.
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      // in_ready is low here, so only a drain into the output can happen.
      if (out_ready) begin
        out_onehot  <= skid_onehot;
        out_instr   <= skid_instr;
        out_pc      <= skid_pc;
        out_illegal <= skid_illegal;
        skid_valid  <= 1'b0;
      end
    end else if (accept) begin
      if (out_free) begin
        out_valid   <= 1'b1;
        out_onehot  <= dec_onehot;
        out_instr   <= in_instr;
        out_pc      <= in_pc;
        out_illegal <= dec_illegal;
      end else begin
        skid_valid   <= 1'b1;
        skid_onehot  <= dec_onehot;
        skid_instr   <= in_instr;
        skid_pc      <= in_pc;
        skid_illegal <= dec_illegal;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (accept && !flush && dec_illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule
